// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: ALU codes, opcode/funct values,
// operand-B source and destination selects, and the ID/EX control bundle.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    BSRC_REG  = 2'd0,
    BSRC_SIMM = 2'd1,
    BSRC_ZIMM = 2'd2
  } bsrc_e;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_RD   = 2'd1,
    DEST_RT   = 2'd2
  } dest_sel_e;

  typedef struct packed {
    logic [3:0] alu_control;
    bsrc_e      b_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
    logic       shamt_en;
  } idex_ctrl_t;

  // Control bundle of an empty pipeline slot.
  function automatic idex_ctrl_t bubble_ctrl();
    idex_ctrl_t c;
    c             = '0;
    c.alu_control = ALU_ADD;
    c.b_src       = BSRC_REG;
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode/funct into ALU code, operand-B source,
// destination select and downstream control bits.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output idex_ctrl_t ctrl,
  output dest_sel_e  dest_sel
);

  // Opcode/funct decode; unknown encodings become a non-writing ADD.
  always_comb begin
    ctrl     = bubble_ctrl();
    dest_sel = DEST_NONE;
    case (opcode)
      OP_RTYPE: begin
        dest_sel       = DEST_RD;
        ctrl.reg_write = 1'b1;
        ctrl.shamt_en  = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_control = ALU_ADD;
          FN_SUB:  ctrl.alu_control = ALU_SUB;
          FN_AND:  ctrl.alu_control = ALU_AND;
          FN_OR:   ctrl.alu_control = ALU_OR;
          FN_NOR:  ctrl.alu_control = ALU_NOR;
          FN_SLT:  ctrl.alu_control = ALU_SLT;
          FN_SLL:  ctrl.alu_control = ALU_SLL;
          default: begin
            ctrl.alu_control = ALU_ADD;
            ctrl.reg_write   = 1'b0;
            ctrl.shamt_en    = 1'b0;
            ctrl.illegal     = 1'b1;
            dest_sel         = DEST_NONE;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl.b_src     = BSRC_SIMM;
        ctrl.reg_write = 1'b1;
        dest_sel       = DEST_RT;
      end
      OP_SLTI: begin
        ctrl.alu_control = ALU_SLT;
        ctrl.b_src       = BSRC_SIMM;
        ctrl.reg_write   = 1'b1;
        dest_sel         = DEST_RT;
      end
      OP_ANDI: begin
        ctrl.alu_control = ALU_AND;
        ctrl.b_src       = BSRC_ZIMM;
        ctrl.reg_write   = 1'b1;
        dest_sel         = DEST_RT;
      end
      OP_ORI: begin
        ctrl.alu_control = ALU_OR;
        ctrl.b_src       = BSRC_ZIMM;
        ctrl.reg_write   = 1'b1;
        dest_sel         = DEST_RT;
      end
      OP_LW: begin
        ctrl.b_src     = BSRC_SIMM;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        dest_sel       = DEST_RT;
      end
      OP_SW: begin
        ctrl.b_src     = BSRC_SIMM;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_control = ALU_SUB;
        ctrl.b_src       = BSRC_SIMM;
        ctrl.branch      = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding that
// drives the EX-stage ALU inputs.
module ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [31:0]   id_instr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_control,
  output logic [4:0]    shamt,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_branch,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_illegal
);

  localparam logic [RW-1:0] IDX_ZERO = {RW{1'b0}};

  idex_ctrl_t    dec_ctrl_s;
  dest_sel_e     dec_dest_s;
  idex_ctrl_t    nxt_ctrl_s;
  logic [RW-1:0] nxt_rd_s;
  logic [RW-1:0] nxt_rs_idx_s;
  logic [RW-1:0] nxt_rt_idx_s;
  logic [DW-1:0] nxt_rs_data_s;
  logic [DW-1:0] nxt_rt_data_s;
  logic [DW-1:0] nxt_imm_s;
  logic [4:0]    nxt_shamt_s;

  idex_ctrl_t    ctrl_r;
  logic          valid_r;
  logic [RW-1:0] rd_r;
  logic [RW-1:0] rs_idx_r;
  logic [RW-1:0] rt_idx_r;
  logic [DW-1:0] rs_data_r;
  logic [DW-1:0] rt_data_r;
  logic [DW-1:0] imm_r;
  logic [4:0]    shamt_r;

  logic [DW-1:0] fwd_rs_s;
  logic [DW-1:0] fwd_rt_s;

  alu_ctrl_decode u_decode (
    .opcode   (id_instr[31:26]),
    .funct    (id_instr[5:0]),
    .ctrl     (dec_ctrl_s),
    .dest_sel (dec_dest_s)
  );

  // Next ID/EX contents: decoded instruction, or a bubble when ID is empty.
  always_comb begin
    nxt_ctrl_s    = bubble_ctrl();
    nxt_rd_s      = IDX_ZERO;
    nxt_rs_idx_s  = IDX_ZERO;
    nxt_rt_idx_s  = IDX_ZERO;
    nxt_rs_data_s = {DW{1'b0}};
    nxt_rt_data_s = {DW{1'b0}};
    nxt_imm_s     = {DW{1'b0}};
    nxt_shamt_s   = 5'd0;
    if (id_valid) begin
      nxt_ctrl_s    = dec_ctrl_s;
      nxt_rs_idx_s  = id_instr[25:21];
      nxt_rt_idx_s  = id_instr[20:16];
      nxt_rs_data_s = id_rs_data;
      nxt_rt_data_s = id_rt_data;
      case (dec_dest_s)
        DEST_RD: nxt_rd_s = id_instr[15:11];
        DEST_RT: nxt_rd_s = id_instr[20:16];
        default: nxt_rd_s = IDX_ZERO;
      endcase
      // Writes to $0 are discarded, so the write is dropped at capture.
      if (nxt_rd_s == IDX_ZERO) begin
        nxt_ctrl_s.reg_write = 1'b0;
      end else begin
        nxt_ctrl_s.reg_write = dec_ctrl_s.reg_write;
      end
      case (dec_ctrl_s.b_src)
        BSRC_SIMM: nxt_imm_s = {{(DW-16){id_instr[15]}}, id_instr[15:0]};
        BSRC_ZIMM: nxt_imm_s = {{(DW-16){1'b0}}, id_instr[15:0]};
        default:   nxt_imm_s = {DW{1'b0}};
      endcase
      if (dec_ctrl_s.shamt_en) begin
        nxt_shamt_s = id_instr[10:6];
      end else begin
        nxt_shamt_s = 5'd0;
      end
    end else begin
      nxt_ctrl_s = bubble_ctrl();
    end
  end

  // Pipeline register: reset and flush share the bubble state; stall holds.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ctrl_r    <= bubble_ctrl();
      valid_r   <= 1'b0;
      rd_r      <= IDX_ZERO;
      rs_idx_r  <= IDX_ZERO;
      rt_idx_r  <= IDX_ZERO;
      rs_data_r <= {DW{1'b0}};
      rt_data_r <= {DW{1'b0}};
      imm_r     <= {DW{1'b0}};
      shamt_r   <= 5'd0;
    end else if (!stall) begin
      ctrl_r    <= nxt_ctrl_s;
      valid_r   <= id_valid;
      rd_r      <= nxt_rd_s;
      rs_idx_r  <= nxt_rs_idx_s;
      rt_idx_r  <= nxt_rt_idx_s;
      rs_data_r <= nxt_rs_data_s;
      rt_data_r <= nxt_rt_data_s;
      imm_r     <= nxt_imm_s;
      shamt_r   <= nxt_shamt_s;
    end
  end

  // Operand forwarding; the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    if (exm_reg_write && (exm_rd != IDX_ZERO) && (exm_rd == rs_idx_r)) begin
      fwd_rs_s = exm_result;
    end else if (wb_reg_write && (wb_rd != IDX_ZERO) && (wb_rd == rs_idx_r)) begin
      fwd_rs_s = wb_data;
    end else begin
      fwd_rs_s = rs_data_r;
    end
    if (exm_reg_write && (exm_rd != IDX_ZERO) && (exm_rd == rt_idx_r)) begin
      fwd_rt_s = exm_result;
    end else if (wb_reg_write && (wb_rd != IDX_ZERO) && (wb_rd == rt_idx_r)) begin
      fwd_rt_s = wb_data;
    end else begin
      fwd_rt_s = rt_data_r;
    end
  end

  // ALU operand select.
  always_comb begin
    alu_a         = fwd_rs_s;
    ex_store_data = fwd_rt_s;
    if (ctrl_r.b_src == BSRC_REG) begin
      alu_b = fwd_rt_s;
    end else begin
      alu_b = imm_r;
    end
  end

  assign alu_control  = ctrl_r.alu_control;
  assign shamt        = shamt_r;
  assign ex_valid     = valid_r;
  assign ex_rd        = rd_r;
  assign ex_reg_write = ctrl_r.reg_write;
  assign ex_mem_read  = ctrl_r.mem_read;
  assign ex_mem_write = ctrl_r.mem_write;
  assign ex_branch    = ctrl_r.branch;
  assign ex_illegal   = ctrl_r.illegal;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage with hand-computed
// expected values.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_instr, id_rs_data, id_rt_data;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_result, wb_data;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_control;
  logic [4:0]  shamt, ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .shamt(shamt),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] rs_d, input logic [31:0] rt_d);
    id_valid   = 1'b1;
    id_instr   = instr;
    id_rs_data = rs_d;
    id_rt_data = rt_d;
  endtask

  task automatic no_fwd();
    exm_reg_write = 1'b0; exm_rd = 5'd0; exm_result = 32'h0;
    wb_reg_write  = 1'b0; wb_rd  = 5'd0; wb_data    = 32'h0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_instr = 32'h0; id_rs_data = 32'h0; id_rt_data = 32'h0;
    no_fwd();
    step();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_aluctl", {28'd0, alu_control}, 32'h2);
    check("rst_regwr", {31'd0, ex_reg_write}, 32'd0);
    check("rst_illegal", {31'd0, ex_illegal}, 32'd0);
    check("rst_alu_a", alu_a, 32'h0);
    rst = 1'b0;

    // add $3,$1,$2
    load(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    step();
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    check("add_ctl", {28'd0, alu_control}, 32'h2);
    check("add_rd", {27'd0, ex_rd}, 32'd3);
    check("add_regwr", {31'd0, ex_reg_write}, 32'd1);
    check("add_valid", {31'd0, ex_valid}, 32'd1);

    // andi $4,$1,0xFFFF
    load(itype(6'h0C, 5'd1, 5'd4, 16'hFFFF), 32'h12345678, 32'h0000DEAD);
    step();
    check("andi_a", alu_a, 32'h12345678);
    check("andi_b", alu_b, 32'h0000FFFF);
    check("andi_ctl", {28'd0, alu_control}, 32'h0);
    check("andi_rd", {27'd0, ex_rd}, 32'd4);

    // addi $5,$1,-1
    load(itype(6'h08, 5'd1, 5'd5, 16'hFFFF), 32'd1, 32'd0);
    step();
    check("addi_b", alu_b, 32'hFFFFFFFF);
    check("addi_ctl", {28'd0, alu_control}, 32'h2);

    // sll $2,$1,4
    load(rtype(5'd0, 5'd1, 5'd2, 5'd4, 6'h00), 32'd0, 32'h11);
    step();
    check("sll_ctl", {28'd0, alu_control}, 32'h3);
    check("sll_shamt", {27'd0, shamt}, 32'd4);
    check("sll_b", alu_b, 32'h11);

    // sub $6,$1,$2 with both stages writing $1
    load(rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h22), 32'd100, 32'd50);
    exm_reg_write = 1'b1; exm_rd = 5'd1; exm_result = 32'd9;
    wb_reg_write  = 1'b1; wb_rd  = 5'd1; wb_data    = 32'd3;
    step();
    check("fwd_exm_a", alu_a, 32'd9);
    check("fwd_exm_b", alu_b, 32'd50);
    check("sub_ctl", {28'd0, alu_control}, 32'h6);
    check("sub_shamt", {27'd0, shamt}, 32'd0);
    exm_reg_write = 1'b0;
    #1;
    check("fwd_wb_a", alu_a, 32'd3);
    wb_reg_write = 1'b0;
    #1;
    check("fwd_none_a", alu_a, 32'd100);

    // add $7,$0,$2 with both stages claiming $0
    load(rtype(5'd0, 5'd2, 5'd7, 5'd0, 6'h20), 32'd0, 32'd50);
    exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'd9;
    wb_reg_write  = 1'b1; wb_rd  = 5'd0; wb_data    = 32'd3;
    step();
    check("fwd_r0_a", alu_a, 32'd0);
    check("fwd_r0_b", alu_b, 32'd50);

    // sw $2,8($1) with EX/MEM writing $2
    load(itype(6'h2B, 5'd1, 5'd2, 16'h0008), 32'h1000, 32'h22);
    no_fwd();
    exm_reg_write = 1'b1; exm_rd = 5'd2; exm_result = 32'hABCD;
    step();
    check("sw_a", alu_a, 32'h1000);
    check("sw_b", alu_b, 32'h8);
    check("sw_store", ex_store_data, 32'hABCD);
    check("sw_memwr", {31'd0, ex_mem_write}, 32'd1);
    check("sw_regwr", {31'd0, ex_reg_write}, 32'd0);
    check("sw_rd", {27'd0, ex_rd}, 32'd0);
    no_fwd();

    // lw $8,-4($1)
    load(itype(6'h23, 5'd1, 5'd8, 16'hFFFC), 32'h2000, 32'h0);
    step();
    check("lw_b", alu_b, 32'hFFFFFFFC);
    check("lw_memrd", {31'd0, ex_mem_read}, 32'd1);
    check("lw_rd", {27'd0, ex_rd}, 32'd8);
    check("lw_regwr", {31'd0, ex_reg_write}, 32'd1);

    // beq $1,$2,3
    load(itype(6'h04, 5'd1, 5'd2, 16'h0003), 32'd4, 32'd4);
    step();
    check("beq_branch", {31'd0, ex_branch}, 32'd1);
    check("beq_ctl", {28'd0, alu_control}, 32'h6);
    check("beq_regwr", {31'd0, ex_reg_write}, 32'd0);

    // stall two cycles, then flush together with stall
    load(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    step();
    stall = 1'b1;
    load(itype(6'h0D, 5'd1, 5'd9, 16'h00F0), 32'h100, 32'h0);
    step();
    check("stall1_a", alu_a, 32'd5);
    check("stall1_rd", {27'd0, ex_rd}, 32'd3);
    step();
    check("stall2_b", alu_b, 32'd7);
    check("stall2_ctl", {28'd0, alu_control}, 32'h2);
    check("stall2_valid", {31'd0, ex_valid}, 32'd1);
    flush = 1'b1;
    step();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_ctl", {28'd0, alu_control}, 32'h2);
    check("flush_regwr", {31'd0, ex_reg_write}, 32'd0);
    check("flush_rd", {27'd0, ex_rd}, 32'd0);
    check("flush_a", alu_a, 32'd0);
    stall = 1'b0; flush = 1'b0;
    step();
    check("ori_b", alu_b, 32'h000000F0);
    check("ori_ctl", {28'd0, alu_control}, 32'h1);
    check("ori_rd", {27'd0, ex_rd}, 32'd9);

    // illegal opcode and funct
    load(itype(6'h3F, 5'd1, 5'd2, 16'h0000), 32'd1, 32'd2);
    step();
    check("ill_op", {31'd0, ex_illegal}, 32'd1);
    check("ill_op_regwr", {31'd0, ex_reg_write}, 32'd0);
    check("ill_op_ctl", {28'd0, alu_control}, 32'h2);
    load(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'd1, 32'd2);
    step();
    check("ill_fn", {31'd0, ex_illegal}, 32'd1);
    check("ill_fn_regwr", {31'd0, ex_reg_write}, 32'd0);

    // addi $0 drops the write
    load(itype(6'h08, 5'd1, 5'd0, 16'h0001), 32'd1, 32'd0);
    step();
    check("r0_regwr", {31'd0, ex_reg_write}, 32'd0);
    check("r0_illegal", {31'd0, ex_illegal}, 32'd0);

    // id_valid low gives a bubble
    id_valid = 1'b0;
    step();
    check("novalid", {31'd0, ex_valid}, 32'd0);

    // reset asserted mid-stall
    load(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    step();
    stall = 1'b1; rst = 1'b1;
    step();
    check("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_mid_rd", {27'd0, ex_rd}, 32'd0);
    check("rst_mid_a", alu_a, 32'd0);
    rst = 1'b0; stall = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
